// File: rtl/p4_router_pkg.sv
// Shared types and widths for the checksum-update engine path.
// chksum_update_req_t is the request layout carried to the engine.
package p4_router_pkg;
  localparam int CHKSUM_UPDATE_REQ_BITS  = 48;
  localparam int CHKSUM_UPDATE_RESP_BITS = 16;

  typedef struct packed {
    logic [15:0] hdr_chk;
    logic [7:0]  pad0;
    logic [7:0]  old_ttl;
    logic [7:0]  pad1;
    logic [7:0]  new_ttl;
  } chksum_update_req_t;

  // Index width that stays at least 1 bit when there is a single requester.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/p4_router_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after r_ptr and,
// on i_advance, moves r_ptr to the slot just past the granted requester.
module p4_router_rr_arbiter
  import p4_router_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = idx_bits(NUM_REQ)
) (
  input  logic               clk,
  input  logic               sreset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_grant_idx
);
  logic [IDW-1:0] r_ptr;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;
  logic           w_found;

  always_comb begin
    w_found     = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    o_grant     = '0;
    o_grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NUM_REQ)) w_sum = w_sum - (IDW+1)'(NUM_REQ);
      w_idx = w_sum[IDW-1:0];
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant_idx    = w_idx;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_grant_idx == IDW'(NUM_REQ - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/p4_router_ipv4_chksum_update_arbiter.sv
// Shares one in-order checksum-update engine among NUM_REQ requesters; a tag FIFO
// routes each reply home. Optional counters: define P4_ROUTER_CHKSUM_ARB_STATS_EN.
module p4_router_ipv4_chksum_update_arbiter
  import p4_router_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int REQ_BITS        = CHKSUM_UPDATE_REQ_BITS,
  parameter int RESP_BITS       = CHKSUM_UPDATE_RESP_BITS,
  localparam int IFW            = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk,
  input  logic                        sreset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*REQ_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [RESP_BITS-1:0]        resp_data,
  output logic                        eng_req_valid,
  output logic [REQ_BITS-1:0]         eng_req_data,
  input  logic                        eng_resp_valid,
  input  logic [RESP_BITS-1:0]        eng_resp_data,
  output logic [IFW-1:0]              in_flight,
  output logic                        err_orphan,
  output logic [NUM_REQ*32-1:0]       stat_grants,
  output logic [15:0]                 stat_orphans
);
  localparam int IDW = idx_bits(NUM_REQ);
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IDW-1:0]       w_grant_idx;
  logic                 w_can_accept;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_orphan;

  logic [IFW-1:0]       r_in_flight;
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [IDW-1:0]       r_tag_mem [MAX_OUTSTANDING];
  logic                 r_eng_req_valid;
  logic [REQ_BITS-1:0]  r_eng_req_data;
  logic [NUM_REQ-1:0]   r_resp_valid;
  logic [RESP_BITS-1:0] r_resp_data;
  logic                 r_err_orphan;

  p4_router_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .clk         (clk),
    .sreset      (sreset),
    .i_req       (req_valid),
    .i_advance   (w_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i];
  // the requester holds valid/data until then. Only the arbitration winner sees
  // ready, and only while the tag FIFO has room (a same-cycle pop does not count).
  // Engine and response paths are strobes with no backpressure.
  assign w_can_accept = (r_in_flight < IFW'(MAX_OUTSTANDING)) && !sreset;
  assign req_ready    = w_grant & {NUM_REQ{w_can_accept}};
  assign w_accept     = |(req_valid & req_ready);
  assign w_pop        = eng_resp_valid && (r_in_flight != '0);
  assign w_orphan     = eng_resp_valid && (r_in_flight == '0);

  always_ff @(posedge clk) begin
    if (w_accept) r_tag_mem[r_wr_ptr] <= w_grant_idx;
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_in_flight     <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_eng_req_valid <= 1'b0;
      r_eng_req_data  <= '0;
      r_resp_valid    <= '0;
      r_resp_data     <= '0;
      r_err_orphan    <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_in_flight <= r_in_flight + 1'b1;
        2'b01:   r_in_flight <= r_in_flight - 1'b1;
        default: r_in_flight <= r_in_flight;
      endcase
      r_eng_req_valid <= w_accept;
      if (w_accept) r_eng_req_data <= req_data[w_grant_idx*REQ_BITS +: REQ_BITS];
      r_resp_valid <= '0;
      if (w_pop) begin
        r_resp_valid[r_tag_mem[r_rd_ptr]] <= 1'b1;
        r_resp_data                       <= eng_resp_data;
      end
      if (w_orphan) r_err_orphan <= 1'b1;
    end
  end

  assign eng_req_valid = r_eng_req_valid;
  assign eng_req_data  = r_eng_req_data;
  assign resp_valid    = r_resp_valid;
  assign resp_data     = r_resp_data;
  assign in_flight     = r_in_flight;
  assign err_orphan    = r_err_orphan;

`ifdef P4_ROUTER_CHKSUM_ARB_STATS_EN
  logic [31:0] r_stat_grants [NUM_REQ];
  logic [15:0] r_stat_orphans;

  // Grant counters wrap; the orphan counter saturates so a storm stays visible.
  always_ff @(posedge clk) begin
    if (sreset) begin
      for (int i = 0; i < NUM_REQ; i++) r_stat_grants[i] <= '0;
      r_stat_orphans <= '0;
    end else begin
      if (w_accept) r_stat_grants[w_grant_idx] <= r_stat_grants[w_grant_idx] + 32'd1;
      if (w_orphan && (r_stat_orphans != 16'hFFFF)) r_stat_orphans <= r_stat_orphans + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    assign stat_grants[gi*32 +: 32] = r_stat_grants[gi];
  end
  assign stat_orphans = r_stat_orphans;
`else
  assign stat_grants  = '0;
  assign stat_orphans = '0;
`endif
endmodule
